alarm_bank: RTL and testbench

- Parametrised multi-alarm store and ring controller; successor to the single-alarm setter.
- Holds N_ALARMS alarm times (hh:mm:ss), each editable per field by held inc/dec buttons with auto-repeat, and each individually enabled.
- Compares against the running clock on every 1 s tick and drives a ring/snooze state machine.
- Sits between the debounced key block and the 7-segment display mux / buzzer driver.

---
 rtl/alarm_bank_if.sv | 25 ++
 rtl/alarm_bank.sv | 217 +++++++++++++++++++++
 tb/tb_alarm_bank.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_if.sv
// Key, time and control inputs of the alarm bank plus its display/ring outputs.
// The master drives keys and time; the slave is the alarm bank itself.
interface alarm_bank_if;
  logic        tick_1s;
  logic [23:0] cur_time;
  logic [2:0]  sel;
  logic [2:0]  cnt_inc;
  logic [2:0]  cnt_dec;
  logic        en_toggle;
  logic        snooze;
  logic        stop;
  logic [31:0] Data;
  logic        ring;
  logic [2:0]  hit_idx;

  modport master (
    output tick_1s, cur_time, sel, cnt_inc, cnt_dec, en_toggle, snooze, stop,
    input  Data, ring, hit_idx
  );

  modport slave (
    input  tick_1s, cur_time, sel, cnt_inc, cnt_dec, en_toggle, snooze, stop,
    output Data, ring, hit_idx
  );
endinterface

// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm store with held-key auto-repeat editing and ring/snooze control.
// Latency: edits and state changes are visible one cycle after the committing edge; Data is combinational.
// Backpressure: none; every input pulse and key level is consumed in the cycle it is sampled.
module alarm_bank #(
  parameter int N_ALARMS    = 4,
  parameter int HOLD_CYC    = 50_000_000,
  parameter int REPEAT_CYC  = 10_000_000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        Clk,
  input  logic        Reset_n,
  alarm_bank_if.slave bus
);

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int SW      = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int IW      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

  localparam logic [CW-1:0] HOLD_V    = CW'(HOLD_CYC);
  localparam logic [CW-1:0] REPEAT_V  = CW'(REPEAT_CYC);
  localparam logic [SW-1:0] RING_LAST = SW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
  localparam logic [3:0]    N_V       = 4'(N_ALARMS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZE
  } state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)            r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == 8'h00)          r = top;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                     r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  logic [23:0]         slot_time [N_ALARMS];
  logic [N_ALARMS-1:0] slot_en;

  logic          sel_ok;
  logic [IW-1:0] didx;
  logic [23:0]   sel_time;
  logic [23:0]   edit_time;

  assign sel_ok   = ({1'b0, bus.sel} < N_V);
  assign didx     = sel_ok ? bus.sel[IW-1:0] : '0;
  assign sel_time = slot_time[didx];
  assign bus.Data = {1'b0, bus.sel, 3'b000, slot_en[didx], sel_time};

  // Keys: bits 2:0 are the increments (sec, min, hour), bits 5:3 the decrements.
  logic [5:0]    key_now;
  logic [5:0]    key_prev;
  logic [5:0]    rep_phase;
  logic [CW-1:0] rep_cnt [6];
  logic [5:0]    key_step;
  logic [2:0]    sel_q;
  logic          sel_chg;

  assign key_now = {bus.cnt_dec, bus.cnt_inc};
  assign sel_chg = (bus.sel != sel_q);

  always_comb begin
    key_step = '0;
    for (int i = 0; i < 6; i++) begin
      if (key_now[i] && !sel_chg) begin
        if (!key_prev[i])                                   key_step[i] = 1'b1;
        else if (!rep_phase[i] && rep_cnt[i] == HOLD_V)     key_step[i] = 1'b1;
        else if (rep_phase[i] && rep_cnt[i] == REPEAT_V)    key_step[i] = 1'b1;
      end
    end
  end

  // A fresh press or a slot switch both restart the hold delay from one.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      key_prev  <= '0;
      rep_phase <= '0;
      sel_q     <= '0;
      for (int i = 0; i < 6; i++) rep_cnt[i] <= '0;
    end else begin
      key_prev <= key_now;
      sel_q    <= bus.sel;
      for (int i = 0; i < 6; i++) begin
        if (!key_now[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (sel_chg || !key_prev[i]) begin
          rep_cnt[i]   <= CW'(1);
          rep_phase[i] <= 1'b0;
        end else if (key_step[i]) begin
          rep_cnt[i]   <= CW'(1);
          rep_phase[i] <= 1'b1;
        end else begin
          rep_cnt[i]   <= rep_cnt[i] + CW'(1);
        end
      end
    end
  end

  logic [2:0] f_inc;
  logic [2:0] f_dec;

  // Opposing steps on one field cancel; independent fields all apply.
  assign f_inc = key_step[2:0] & ~key_step[5:3];
  assign f_dec = key_step[5:3] & ~key_step[2:0];

  assign edit_time[7:0]   = f_inc[0] ? bcd_inc(sel_time[7:0], 8'h59)   :
                            f_dec[0] ? bcd_dec(sel_time[7:0], 8'h59)   : sel_time[7:0];
  assign edit_time[15:8]  = f_inc[1] ? bcd_inc(sel_time[15:8], 8'h59)  :
                            f_dec[1] ? bcd_dec(sel_time[15:8], 8'h59)  : sel_time[15:8];
  assign edit_time[23:16] = f_inc[2] ? bcd_inc(sel_time[23:16], 8'h23) :
                            f_dec[2] ? bcd_dec(sel_time[23:16], 8'h23) : sel_time[23:16];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      slot_en <= '0;
      for (int k = 0; k < N_ALARMS; k++) slot_time[k] <= '0;
    end else if (sel_ok) begin
      slot_time[didx] <= edit_time;
      if (bus.en_toggle) slot_en[didx] <= ~slot_en[didx];
    end
  end

  logic       match_vld;
  logic [2:0] match_idx;

  // Scanning downward leaves the lowest matching slot as the winner.
  always_comb begin
    match_vld = 1'b0;
    match_idx = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (slot_en[k] && slot_time[k] == bus.cur_time) begin
        match_vld = 1'b1;
        match_idx = 3'(k);
      end
    end
  end

  state_t        state, nxt_state;
  logic [SW-1:0] sec_cnt, nxt_sec;
  logic [2:0]    hit_q, nxt_hit;
  logic          hit_disable;

  assign hit_disable = bus.en_toggle && sel_ok && (bus.sel == hit_q) && slot_en[hit_q[IW-1:0]];

  always_comb begin
    nxt_state = state;
    nxt_sec   = sec_cnt;
    nxt_hit   = hit_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.tick_1s && match_vld) begin
          nxt_state = ST_RINGING;
          nxt_hit   = match_idx;
          nxt_sec   = '0;
        end
      end
      ST_RINGING: begin
        if (bus.stop || hit_disable) begin
          nxt_state = ST_IDLE;
        end else if (bus.snooze) begin
          nxt_state = ST_SNOOZE;
          nxt_sec   = '0;
        end else if (bus.tick_1s) begin
          if (sec_cnt == RING_LAST) nxt_state = ST_IDLE;
          else                      nxt_sec   = sec_cnt + SW'(1);
        end
      end
      ST_SNOOZE: begin
        if (bus.stop || hit_disable) begin
          nxt_state = ST_IDLE;
        end else if (bus.tick_1s && match_vld) begin
          nxt_state = ST_RINGING;
          nxt_hit   = match_idx;
          nxt_sec   = '0;
        end else if (bus.tick_1s) begin
          if (sec_cnt == SNZ_LAST) begin
            nxt_state = ST_RINGING;
            nxt_sec   = '0;
          end else begin
            nxt_sec = sec_cnt + SW'(1);
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      sec_cnt <= '0;
      hit_q   <= '0;
    end else begin
      state   <= nxt_state;
      sec_cnt <= nxt_sec;
      hit_q   <= nxt_hit;
    end
  end

  assign bus.ring    = (state == ST_RINGING);
  assign bus.hit_idx = hit_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: directed vector table for the documented scenarios, then
// randomized traffic against a field-level reference model.
module tb_alarm_bank;
  localparam int NA   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int RS   = 3;
  localparam int SS   = 2;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  alarm_bank_if bus ();

  alarm_bank #(
    .N_ALARMS(NA), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .RING_SECS(RS), .SNOOZE_SECS(SS)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          rst_n;
    logic [2:0]  sel, inc, dec;
    bit          tog, tick, snz, stp;
    logic [23:0] cur;
    int          reps;
    logic [31:0] d;
    bit          r;
    logic [2:0]  h;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst_n, input logic [2:0] sel, inc, dec, input bit tog, tick, snz, stp,
                     input logic [23:0] cur, input int reps, input logic [31:0] d, input bit r, input logic [2:0] h);
    vec_t v;
    v.rst_n = rst_n; v.sel = sel; v.inc = inc; v.dec = dec;
    v.tog = tog; v.tick = tick; v.snz = snz; v.stp = stp;
    v.cur = cur; v.reps = reps; v.d = d; v.r = r; v.h = h;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit rst_n, input logic [2:0] sel, inc, dec, input bit tog, tick, snz, stp,
                       input logic [23:0] cur);
    Reset_n       = rst_n;
    bus.sel       = sel;
    bus.cnt_inc   = inc;
    bus.cnt_dec   = dec;
    bus.en_toggle = tog;
    bus.tick_1s   = tick;
    bus.snooze    = snz;
    bus.stop      = stp;
    bus.cur_time  = cur;
  endtask

  task automatic check(input string nm, input logic [31:0] ed, input bit er, input logic [2:0] eh);
    n_vec++;
    if (bus.Data !== ed || bus.ring !== er || bus.hit_idx !== eh) begin
      n_bad++;
      $display("FAIL %s: got Data=%h ring=%b hit_idx=%0d, want Data=%h ring=%b hit_idx=%0d",
               nm, bus.Data, bus.ring, bus.hit_idx, ed, er, eh);
    end
  endtask

  // Reference model: alarm fields as plain integers, ring/snooze as flags with a ticks-remaining count.
  int  m_t [NA][3];
  bit  m_en [NA];
  bit  m_ring, m_snz;
  int  m_left, m_hit, m_psel;
  int  m_h [6];

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic logic [23:0] slot_bcd(input int k);
    return {bcd(m_t[k][2]), bcd(m_t[k][1]), bcd(m_t[k][0])};
  endfunction

  function automatic logic [31:0] exp_data(input logic [2:0] sel);
    int ds;
    ds = (sel < NA) ? int'(sel) : 0;
    return {1'b0, sel, 3'b000, m_en[ds], slot_bcd(ds)};
  endfunction

  task automatic model_edge(input bit rst_n, input logic [2:0] sel, inc, dec, input bit tog, tick, snz, stp,
                            input logic [23:0] cur);
    int mk, lim;
    bit dis;
    bit [5:0] st;
    logic [5:0] keys;
    if (!rst_n) begin
      for (int k = 0; k < NA; k++) begin
        m_en[k] = 0;
        for (int f = 0; f < 3; f++) m_t[k][f] = 0;
      end
      for (int i = 0; i < 6; i++) m_h[i] = 0;
      m_ring = 0; m_snz = 0; m_left = 0; m_hit = 0; m_psel = 0;
      return;
    end
    mk = -1;
    if (tick)
      for (int k = NA - 1; k >= 0; k--)
        if (m_en[k] && slot_bcd(k) == cur) mk = k;
    dis = tog && (sel < NA) && (int'(sel) == m_hit) && m_en[m_hit];
    if (!m_ring && !m_snz) begin
      if (mk >= 0) begin m_ring = 1; m_hit = mk; m_left = RS; end
    end else if (stp || dis) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring) begin
      if (snz) begin m_ring = 0; m_snz = 1; m_left = SS; end
      else if (tick) begin m_left--; if (m_left == 0) m_ring = 0; end
    end else if (tick) begin
      if (mk >= 0) begin m_snz = 0; m_ring = 1; m_hit = mk; m_left = RS; end
      else begin
        m_left--;
        if (m_left == 0) begin m_snz = 0; m_ring = 1; m_left = RS; end
      end
    end
    keys = {dec, inc};
    st = '0;
    for (int i = 0; i < 6; i++) begin
      if (!keys[i]) m_h[i] = 0;
      else begin
        m_h[i]++;
        if (int'(sel) != m_psel) m_h[i] = 1;
        else if (m_h[i] == 1) st[i] = 1;
        else st[i] = (m_h[i] - 1 == HOLD) || (m_h[i] - 1 > HOLD && (m_h[i] - 1 - HOLD) % REP == 0);
      end
    end
    if (sel < NA) begin
      for (int f = 0; f < 3; f++) begin
        lim = (f == 2) ? 24 : 60;
        if (st[f] && !st[f+3])      m_t[sel][f] = (m_t[sel][f] + 1) % lim;
        else if (st[f+3] && !st[f]) m_t[sel][f] = (m_t[sel][f] + lim - 1) % lim;
      end
      if (tog) m_en[sel] = !m_en[sel];
    end
    m_psel = int'(sel);
  endtask

  logic [2:0]  r_sel, r_inc, r_dec;
  bit          r_rst, r_tog, r_tick, r_snz, r_stp;
  logic [23:0] r_cur;
  int          b;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 24'h0);

    //  rst sel inc     dec     tog tk snz stp cur        reps  Data          ring hit
    add(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 2,   32'h0000_0000, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_0000, 0, 0);
    add(1, 0, 3'b001, 3'b000, 0, 0, 0, 0, 24'h000000, 20,  32'h0000_0004, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_0004, 0, 0);
    add(1, 0, 3'b000, 3'b001, 0, 0, 0, 0, 24'h000000, 21,  32'h0000_0059, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_0059, 0, 0);
    add(1, 0, 3'b001, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_0000, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_0000, 0, 0);
    add(1, 0, 3'b000, 3'b010, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5900, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5900, 0, 0);
    add(1, 0, 3'b100, 3'b100, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5900, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5900, 0, 0);
    add(1, 0, 3'b000, 3'b100, 0, 0, 0, 0, 24'h000000, 1,   32'h0023_5900, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0023_5900, 0, 0);
    add(1, 0, 3'b100, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5900, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5900, 0, 0);
    add(1, 0, 3'b001, 3'b010, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5801, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_5801, 0, 0);
    add(1, 2, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h2000_0000, 0, 0);
    add(1, 2, 3'b100, 3'b000, 0, 0, 0, 0, 24'h000000, 29,  32'h2007_0000, 0, 0);
    add(1, 2, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h2007_0000, 0, 0);
    add(1, 2, 3'b010, 3'b000, 0, 0, 0, 0, 24'h000000, 121, 32'h2007_3000, 0, 0);
    add(1, 2, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h2007_3000, 0, 0);
    add(1, 2, 3'b000, 3'b000, 1, 0, 0, 0, 24'h000000, 1,   32'h2107_3000, 0, 0);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073000, 1,   32'h2107_3000, 1, 2);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073001, 1,   32'h2107_3000, 1, 2);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073001, 1,   32'h2107_3000, 1, 2);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073001, 1,   32'h2107_3000, 0, 2);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073000, 1,   32'h2107_3000, 1, 2);
    add(1, 2, 3'b000, 3'b000, 0, 0, 1, 0, 24'h073000, 1,   32'h2107_3000, 0, 2);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073001, 1,   32'h2107_3000, 0, 2);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073001, 1,   32'h2107_3000, 1, 2);
    add(1, 2, 3'b000, 3'b000, 0, 0, 1, 1, 24'h073001, 1,   32'h2107_3000, 0, 2);
    add(1, 2, 3'b000, 3'b000, 0, 1, 0, 0, 24'h073001, 2,   32'h2107_3000, 0, 2);
    add(1, 1, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h1000_0000, 0, 2);
    add(1, 1, 3'b001, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h1000_0001, 0, 2);
    add(1, 1, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h1000_0001, 0, 2);
    add(1, 1, 3'b000, 3'b000, 1, 0, 0, 0, 24'h000000, 1,   32'h1100_0001, 0, 2);
    add(1, 3, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h3000_0000, 0, 2);
    add(1, 3, 3'b001, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h3000_0001, 0, 2);
    add(1, 3, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h3000_0001, 0, 2);
    add(1, 3, 3'b000, 3'b000, 1, 0, 0, 0, 24'h000000, 1,   32'h3100_0001, 0, 2);
    add(1, 3, 3'b000, 3'b000, 0, 1, 0, 0, 24'h000001, 1,   32'h3100_0001, 1, 1);
    add(1, 1, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000001, 1,   32'h1100_0001, 1, 1);
    add(1, 1, 3'b000, 3'b000, 1, 0, 0, 0, 24'h000001, 1,   32'h1000_0001, 0, 1);
    add(1, 3, 3'b000, 3'b000, 0, 1, 0, 0, 24'h000001, 1,   32'h3100_0001, 1, 3);
    add(0, 3, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000001, 1,   32'h3000_0000, 0, 0);
    add(1, 1, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h1000_0000, 0, 0);
    add(1, 5, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h5000_0000, 0, 0);
    add(1, 5, 3'b001, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h5000_0000, 0, 0);
    add(1, 5, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h5000_0000, 0, 0);
    add(1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h0000_0000, 0, 0);
    add(1, 0, 3'b001, 3'b000, 0, 0, 0, 0, 24'h000000, 5,   32'h0000_0001, 0, 0);
    add(1, 2, 3'b001, 3'b000, 0, 0, 0, 0, 24'h000000, 10,  32'h2000_0001, 0, 0);
    add(1, 2, 3'b000, 3'b000, 0, 0, 0, 0, 24'h000000, 1,   32'h2000_0001, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        drive(tbl[i].rst_n, tbl[i].sel, tbl[i].inc, tbl[i].dec, tbl[i].tog, tbl[i].tick,
              tbl[i].snz, tbl[i].stp, tbl[i].cur);
        @(posedge Clk);
        #1;
      end
      check($sformatf("row%0d", i), tbl[i].d, tbl[i].r, tbl[i].h);
    end

    // Randomized phase: both model and DUT start from reset.
    r_sel = 0; r_inc = 0; r_dec = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst  = (c < 2) || ($urandom % 700 == 0);
      if ($urandom % 24 == 0) r_sel = ($urandom % 4 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
      if ($urandom % 6 == 0) begin
        b = $urandom % 6;
        if (b < 3) r_inc[b] = ~r_inc[b];
        else       r_dec[b-3] = ~r_dec[b-3];
      end
      r_tog  = ($urandom % 16 == 0);
      r_tick = ($urandom % 4 == 0);
      r_snz  = ($urandom % 20 == 0);
      r_stp  = ($urandom % 40 == 0);
      if ($urandom % 3 == 0) r_cur = slot_bcd($urandom % NA);
      else                   r_cur = {bcd($urandom % 24), bcd($urandom % 60), bcd($urandom % 60)};
      drive(!r_rst, r_sel, r_inc, r_dec, r_tog, r_tick, r_snz, r_stp, r_cur);
      @(posedge Clk);
      #1;
      model_edge(!r_rst, r_sel, r_inc, r_dec, r_tog, r_tick, r_snz, r_stp, r_cur);
      check($sformatf("rand%0d", c), exp_data(r_sel), m_ring, 3'(m_hit));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
